// File: rtl/mem_datos_dual_sync.sv
// Dual-port data memory for the two MEM-stage slots.
// Registered reads, same-cycle conflict resolution, range errors.
module mem_datos_dual_sync #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 16,
  parameter logic [31:0]      BASE_ADDR    = 32'h10000000,
  parameter logic [WIDTH-1:0] DEFAULT_DATA = WIDTH'(32'h00000020)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Mem_rd_1,
  input  logic             Mem_rd_2,
  input  logic             Mem_wr_1,
  input  logic             Mem_wr_2,
  input  logic [31:0]      Dir_Mem_1,
  input  logic [31:0]      Dir_Mem_2,
  input  logic [WIDTH-1:0] Dato_Mem_in_1,
  input  logic [WIDTH-1:0] Dato_Mem_in_2,
  output logic [WIDTH-1:0] Dato_Mem_out_1,
  output logic [WIDTH-1:0] Dato_Mem_out_2,
  output logic             Dato_valid_1,
  output logic             Dato_valid_2,
  output logic             Err_1,
  output logic             Err_2,
  output logic [7:0]       Err_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out_1, r_out_2;
  logic             r_valid_1, r_valid_2;
  logic             r_err_1, r_err_2;
  logic [7:0]       r_cnt;

  logic [31:0]   w_off_1, w_off_2;
  logic          w_in_1, w_in_2;
  logic [AW-1:0] w_idx_1, w_idx_2;
  logic          w_rd_1, w_rd_2, w_wr_1, w_wr_2;
  logic          w_err_1, w_err_2;
  logic          w_fwd_2;
  logic [8:0]    w_sum;
  logic [7:0]    w_cnt_nxt;

  // Offset is only trusted once Dir >= BASE rules out wrap-around.
  assign w_off_1 = Dir_Mem_1 - BASE_ADDR;
  assign w_off_2 = Dir_Mem_2 - BASE_ADDR;
  assign w_in_1  = (Dir_Mem_1 >= BASE_ADDR) && (w_off_1 < SPAN)
                   && (Dir_Mem_1[1:0] == 2'b00);
  assign w_in_2  = (Dir_Mem_2 >= BASE_ADDR) && (w_off_2 < SPAN)
                   && (Dir_Mem_2[1:0] == 2'b00);
  assign w_idx_1 = w_off_1[AW+1:2];
  assign w_idx_2 = w_off_2[AW+1:2];

  assign w_rd_1  = ~Mem_rd_1;
  assign w_rd_2  = ~Mem_rd_2;
  assign w_wr_1  = Mem_rd_1 & ~Mem_wr_1;
  assign w_wr_2  = Mem_rd_2 & ~Mem_wr_2;
  assign w_err_1 = (w_rd_1 | w_wr_1) & ~w_in_1;
  assign w_err_2 = (w_rd_2 | w_wr_2) & ~w_in_2;

  // Older slot's store forwards to the younger slot's load.
  assign w_fwd_2 = w_wr_1 & w_in_1 & w_rd_2 & w_in_2
                   & (w_idx_1 == w_idx_2);

  assign w_sum     = {1'b0, r_cnt} + 9'(w_err_1) + 9'(w_err_2);
  assign w_cnt_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 4; i < DEPTH; i++) r_mem[i] <= '0;
      r_mem[0]  <= WIDTH'(32'h8);
      r_mem[1]  <= WIDTH'(32'hD);
      r_mem[2]  <= WIDTH'(32'h2);
      r_mem[3]  <= WIDTH'(32'h10);
      r_out_1   <= '0;
      r_out_2   <= '0;
      r_valid_1 <= 1'b0;
      r_valid_2 <= 1'b0;
      r_err_1   <= 1'b0;
      r_err_2   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // Slot 2 written last so the younger store wins.
      if (w_wr_1 && w_in_1) r_mem[w_idx_1] <= Dato_Mem_in_1;
      if (w_wr_2 && w_in_2) r_mem[w_idx_2] <= Dato_Mem_in_2;
      if (w_rd_1)
        r_out_1 <= w_in_1 ? r_mem[w_idx_1] : DEFAULT_DATA;
      if (w_rd_2)
        r_out_2 <= !w_in_2 ? DEFAULT_DATA :
                   w_fwd_2 ? Dato_Mem_in_1 : r_mem[w_idx_2];
      r_valid_1 <= w_rd_1;
      r_valid_2 <= w_rd_2;
      r_err_1   <= w_err_1;
      r_err_2   <= w_err_2;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign Dato_Mem_out_1 = r_out_1;
  assign Dato_Mem_out_2 = r_out_2;
  assign Dato_valid_1   = r_valid_1;
  assign Dato_valid_2   = r_valid_2;
  assign Err_1          = r_err_1;
  assign Err_2          = r_err_2;
  assign Err_cnt        = r_cnt;

endmodule

// File: tb/tb_mem_datos_dual_sync.sv
// Scoreboard bench for mem_datos_dual_sync.
// Stimulus pushes expected responses; a negedge monitor pops them.
module tb_mem_datos_dual_sync;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  localparam int IDLE = 0;
  localparam int RD   = 1;
  localparam int WR   = 2;
  localparam int RDWR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Mem_rd_1 = 1'b1, Mem_rd_2 = 1'b1;
  logic        Mem_wr_1 = 1'b1, Mem_wr_2 = 1'b1;
  logic [31:0] Dir_Mem_1 = '0, Dir_Mem_2 = '0;
  logic [31:0] Dato_Mem_in_1 = '0, Dato_Mem_in_2 = '0;
  logic [31:0] Dato_Mem_out_1, Dato_Mem_out_2;
  logic        Dato_valid_1, Dato_valid_2;
  logic        Err_1, Err_2;
  logic [7:0]  Err_cnt;

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_datos_dual_sync dut (
    .clk(clk), .rst(rst),
    .Mem_rd_1(Mem_rd_1), .Mem_rd_2(Mem_rd_2),
    .Mem_wr_1(Mem_wr_1), .Mem_wr_2(Mem_wr_2),
    .Dir_Mem_1(Dir_Mem_1), .Dir_Mem_2(Dir_Mem_2),
    .Dato_Mem_in_1(Dato_Mem_in_1), .Dato_Mem_in_2(Dato_Mem_in_2),
    .Dato_Mem_out_1(Dato_Mem_out_1), .Dato_Mem_out_2(Dato_Mem_out_2),
    .Dato_valid_1(Dato_valid_1), .Dato_valid_2(Dato_valid_2),
    .Err_1(Err_1), .Err_2(Err_2),
    .Err_cnt(Err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input string nm, inout exp_t q[$],
                     input logic v, input logic e,
                     input logic [31:0] d);
    exp_t x;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected v=%b e=%b d=%h", nm, v, e, d);
    end else begin
      x = q.pop_front();
      if (v !== x.rd || e !== x.err || (x.rd && d !== x.data)) begin
        n_fail++;
        $display("FAIL %s: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 nm, v, e, d, x.rd, x.err, x.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (Dato_valid_1 || Err_1)
      mon("port1", q1, Dato_valid_1, Err_1, Dato_Mem_out_1);
    if (Dato_valid_2 || Err_2)
      mon("port2", q2, Dato_valid_2, Err_2, Dato_Mem_out_2);
  end

  task automatic e1(input logic rd, input logic err,
                    input logic [31:0] d);
    q1.push_back('{rd: rd, err: err, data: d});
  endtask

  task automatic e2(input logic rd, input logic err,
                    input logic [31:0] d);
    q2.push_back('{rd: rd, err: err, data: d});
  endtask

  task automatic drive(input int o1, input logic [31:0] a1,
                       input logic [31:0] d1, input int o2,
                       input logic [31:0] a2, input logic [31:0] d2);
    Mem_rd_1 = !(o1 == RD || o1 == RDWR);
    Mem_wr_1 = !(o1 == WR || o1 == RDWR);
    Mem_rd_2 = !(o2 == RD || o2 == RDWR);
    Mem_wr_2 = !(o2 == WR || o2 == RDWR);
    Dir_Mem_1 = a1; Dato_Mem_in_1 = d1;
    Dir_Mem_2 = a2; Dato_Mem_in_2 = d2;
    @(posedge clk); #1;
    Mem_rd_1 = 1'b1; Mem_wr_1 = 1'b1;
    Mem_rd_2 = 1'b1; Mem_wr_2 = 1'b1;
  endtask

  task automatic idle();
    drive(IDLE, 0, 0, IDLE, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out1", Dato_Mem_out_1, 0);
    chk("rst_out2", Dato_Mem_out_2, 0);
    chk("rst_valid", {Dato_valid_1, Dato_valid_2}, 0);
    chk("rst_err", {Err_1, Err_2}, 0);
    chk("rst_cnt", Err_cnt, 0);
    rst = 1'b0;

    // Reset contents of words 1 and 3
    e1(1, 0, 32'hD); e2(1, 0, 32'h10);
    drive(RD, 32'h10000004, 0, RD, 32'h1000000C, 0);
    idle();
    chk("valid_one_pulse", {Dato_valid_1, Dato_valid_2}, 0);
    chk("cnt_after_reads", Err_cnt, 0);

    // Both write same word: younger wins
    drive(WR, 32'h10000008, 32'hAAAA, WR, 32'h10000008, 32'hBBBB);
    e1(1, 0, 32'hBBBB);
    drive(RD, 32'h10000008, 0, IDLE, 0, 0);

    // Slot 1 store forwards to slot 2 load
    e2(1, 0, 32'h1234);
    drive(WR, 32'h10000000, 32'h1234, RD, 32'h10000000, 0);
    // Slot 1 load sees pre-write value
    e1(1, 0, 32'h1234);
    drive(RD, 32'h10000000, 0, WR, 32'h10000000, 32'h5678);
    e1(1, 0, 32'h5678);
    drive(RD, 32'h10000000, 0, IDLE, 0, 0);

    // Read has priority over write on the same slot
    e1(1, 0, 32'hD);
    drive(RDWR, 32'h10000004, 32'hFFFF, IDLE, 0, 0);
    e1(1, 0, 32'hD);
    drive(RD, 32'h10000004, 0, IDLE, 0, 0);

    // Out of range read + misaligned write
    e1(1, 1, 32'h20); e2(0, 1, 0);
    drive(RD, 32'h20000000, 0, WR, 32'h10000002, 32'h9999);
    chk("cnt_two_err", Err_cnt, 2);
    e1(1, 0, 32'h5678); e2(1, 0, 32'hBBBB);
    drive(RD, 32'h10000000, 0, RD, 32'h10000008, 0);

    // Range boundaries: one past end, last word, below base
    e1(1, 1, 32'h20); e2(1, 0, 32'h0);
    drive(RD, 32'h10000040, 0, RD, 32'h1000003C, 0);
    chk("cnt_boundary", Err_cnt, 3);
    e1(1, 1, 32'h20);
    drive(RD, 32'h0FFFFFFC, 0, IDLE, 0, 0);
    chk("cnt_below_base", Err_cnt, 4);

    // Saturation: 4 + 2k hits 254 then 255
    for (int i = 0; i < 130; i++) begin
      e1(1, 1, 32'h20); e2(0, 1, 0);
      drive(RD, 32'h20000000, 0, WR, 32'h0FFFFFFC, 32'h1);
      ec = 4 + 2 * (i + 1);
      if (ec > 255) ec = 255;
      chk($sformatf("cnt_sat_%0d", i), Err_cnt, 32'(ec));
    end
    idle();

    // Reset with a request pending: request ignored
    rst = 1'b1;
    drive(WR, 32'h10000000, 32'hDEAD, IDLE, 0, 0);
    rst = 1'b0;
    chk("rst2_cnt", Err_cnt, 0);
    chk("rst2_out1", Dato_Mem_out_1, 0);
    e1(1, 0, 32'h8); e2(1, 0, 32'h2);
    drive(RD, 32'h10000000, 0, RD, 32'h10000008, 0);

    // Idle ports hold data, no pulses
    for (int i = 0; i < 5; i++) begin
      idle();
      chk($sformatf("hold1_%0d", i), Dato_Mem_out_1, 32'h8);
      chk($sformatf("hold2_%0d", i), Dato_Mem_out_2, 32'h2);
      chk($sformatf("holdv_%0d", i), {Dato_valid_1, Dato_valid_2}, 0);
    end

    repeat (2) idle();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_datos_dual_sync.md
# mem_datos_dual_sync

Parametrised dual-port data memory for the superscalar datapath, replacing the fixed four-word, combinational data memory. Serves the two MEM-stage slots (slot 1 = older instruction, slot 2 = younger) with synchronous writes, registered reads and defined same-cycle conflict resolution. It also adds out-of-range detection and a saturating error counter for debug.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 16, number of words; power of two, ≥ 4
- BASE_ADDR, 32'h10000000, byte address of word 0
- DEFAULT_DATA, 32'h00000020, read data returned for out-of-range reads
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Mem_rd_1 / Mem_rd_2  in  1  read strobe, active-low
- Mem_wr_1 / Mem_wr_2  in  1  write strobe, active-low
- Dir_Mem_1 / Dir_Mem_2  in  32  byte address
- Dato_Mem_in_1 / Dato_Mem_in_2  in  WIDTH  write data
- Dato_Mem_out_1 / Dato_Mem_out_2  out  WIDTH  registered read data
- Dato_valid_1 / Dato_valid_2  out  1  one-cycle pulse: read data updated
- Err_1 / Err_2  out  1  one-cycle pulse: previous access out of range
- Err_cnt  out  8  saturating count of out-of-range accesses

## Operation
- Per port, request decode: rd low → read (rd has priority); else wr low → write; else idle.
- In range: Dir ≥ BASE_ADDR, Dir < BASE_ADDR + 4·DEPTH, Dir[1:0] = 0. Word index = (Dir − BASE_ADDR) >> 2, log2(DEPTH) bits.
- Write, in range: word updated at the edge.
- Write, out of range: write dropped; Err_x pulses; Err_cnt increments.
- Read, in range: Dato_Mem_out_x loads the word at the edge; Dato_valid_x pulses.
- Read, out of range: Dato_Mem_out_x loads DEFAULT_DATA; Dato_valid_x and Err_x pulse; Err_cnt increments.
- Idle port: Dato_Mem_out_x holds its last value; valid and err are 0.
- Same-cycle conflicts, same word index:
  - Both write: slot 2 data stored (younger wins).
  - Slot 1 reads, slot 2 writes: slot 1 gets the pre-write value.
  - Slot 2 reads, slot 1 writes: slot 2 gets Dato_Mem_in_1 (forwarded).
  - Both read: both get the stored value.
- Err_cnt:
  - Adds 0, 1 or 2 per cycle (one per erroneous port).
  - Saturates at 255 and never wraps; 254 + 2 → 255.

## Timing
- Read latency is 1 cycle: request sampled at edge N; data, valid and err are visible after edge N.
- Write data is visible to a read issued on the next cycle.
- Same-cycle read behaviour follows the conflict rules above.
- Back-to-back accesses every cycle on both ports are supported with no stalls.
- Reset (rst high at an edge):
  - Words 0–3 load 32'h8, 32'hD, 32'h2, 32'h10; all other words load 0.
  - Dato_Mem_out_x = 0, Dato_valid_x = 0, Err_x = 0, Err_cnt = 0.
  - Reset dominates: requests presented in a reset cycle are ignored. A write in flight when reset asserts is lost.
- First accesses are accepted on the first edge with rst low.

## Test plan
- Reset, then slot 1 reads 0x10000004 and slot 2 reads 0x1000000C → one cycle later out_1 = 0xD, out_2 = 0x10, both valid pulse once, Err_cnt = 0.
- Both slots write 0x10000008 (slot 1 = 0xAAAA, slot 2 = 0xBBBB), then slot 1 reads it next cycle → out_1 = 0xBBBB.
- Same cycle: slot 1 writes 0x1234 to 0x10000000 while slot 2 reads 0x10000000 → out_2 = 0x1234. Reverse roles (slot 2 writes 0x5678, slot 1 reads) → out_1 = 0x1234.
- Slot 1 reads 0x20000000, slot 2 writes 0x10000002 → out_1 = 0x20, Err_1 and Err_2 pulse, Err_cnt = 2, memory unchanged.
- 130 cycles of dual out-of-range accesses → Err_cnt reaches 255 and stays there; then rst for one cycle → Err_cnt = 0, word 0 = 0x8.
- Idle ports for 5 cycles after a read → outputs hold their value, valid stays 0.
